audio_tx: RTL

//   I2S/left-justified DAC serialiser for the WM8731 path, codec in master mode (codec drives BCLK/DACLRC).

---
 rtl/audio_pkg.sv | 18 +
 rtl/audio_tx_fifo.sv | 54 +++++
 rtl/audio_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// ============================================================================
// Module  : audio_pkg
// Brief   : Shared constants and types for the WM8731 audio serial path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;
  localparam int   AUDIO_WORD_LEN = 32;
  localparam logic LRC_LEFT       = 1'b1;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } stereo_pair_t;
endpackage

`default_nettype wire

// File: rtl/audio_tx_fifo.sv
// ============================================================================
// Module  : audio_tx_fifo
// Brief   : Show-ahead synchronous FIFO of stereo pairs, async reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_tx_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  stereo_pair_t                  wr_data,
  input  logic                          rd_en,
  output stereo_pair_t                  rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);

  stereo_pair_t  r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_wr;
  logic          w_rd;

  // One extra pointer bit distinguishes full from empty.
  assign level   = r_wr_ptr - r_rd_ptr;
  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign w_wr    = wr_en & ~full;
  assign w_rd    = rd_en & ~empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/audio_tx.sv
// ============================================================================
// Module  : audio_tx
// Brief   : Left-justified DAC serialiser for a codec-mastered BCLK/LRC.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_tx
  import audio_pkg::*;
#(
  parameter int WORD_LEN   = AUDIO_WORD_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sck_bclk,
  input  logic                          ws_lrc,
  output logic                          sdata,
  input  logic [31:0]                   left_data,
  input  logic [31:0]                   right_data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  // Keeps the top WORD_LEN bits so the tail of each slot shifts out as zeros.
  localparam logic [31:0] c_word_mask = ~(32'hFFFF_FFFF >> WORD_LEN);

  logic         r_bclk_d0, r_bclk_d1;
  logic         r_lrc_d0,  r_lrc_d1;
  logic [31:0]  r_shift;
  logic [31:0]  r_hold;
  logic         r_sdata;
  logic         r_underrun;

  logic         w_bclk_fall;
  logic         w_left_start;
  logic         w_right_start;
  logic         w_full;
  logic         w_empty;
  stereo_pair_t w_wr_pair;
  stereo_pair_t w_rd_pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bclk_d0 <= 1'b0;
      r_bclk_d1 <= 1'b0;
      r_lrc_d0  <= 1'b0;
      r_lrc_d1  <= 1'b0;
    end else begin
      r_bclk_d0 <= sck_bclk;
      r_bclk_d1 <= r_bclk_d0;
      r_lrc_d0  <= ws_lrc;
      r_lrc_d1  <= r_lrc_d0;
    end
  end

  assign w_bclk_fall   = r_bclk_d1 & ~r_bclk_d0;
  assign w_left_start  = (r_lrc_d0 == LRC_LEFT) && (r_lrc_d1 != LRC_LEFT);
  assign w_right_start = (r_lrc_d0 != LRC_LEFT) && (r_lrc_d1 == LRC_LEFT);

  assign w_wr_pair.left  = left_data;
  assign w_wr_pair.right = right_data;

  audio_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (data_valid),
    .wr_data (w_wr_pair),
    .rd_en   (w_left_start),
    .rd_data (w_rd_pair),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // A slot load takes priority over the coincident BCLK-fall shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_hold     <= '0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_sdata    <= r_shift[31];
      r_underrun <= 1'b0;
      if (w_left_start) begin
        if (!w_empty) begin
          r_shift <= w_rd_pair.left & c_word_mask;
          r_hold  <= w_rd_pair.right;
        end else begin
          r_shift    <= '0;
          r_hold     <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_right_start) begin
        r_shift <= r_hold & c_word_mask;
      end else if (w_bclk_fall) begin
        r_shift <= {r_shift[30:0], 1'b0};
      end
    end
  end

  assign sdata      = r_sdata;
  assign underrun   = r_underrun;
  assign data_ready = ~w_full;
endmodule

`default_nettype wire
